ramp_dac: RTL and testbench

Digital-to-analog output stage for the SV-RNM mixed-signal models. It is the return path for the flash ADC's n-bit code. The block accepts an n-bit code through a valid/ready handshake and moves an internal code register toward it at a bounded slew, one step per clock. It then waits a fixed settling time and drives a real-valued mid-code voltage `VOUT`, so a round trip through the flash ADC reproduces the code.

---
 rtl/ramp_dac.sv | 102 ++++++++++
 tb/tb_ramp_dac.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ramp_dac.sv
// ramp_dac: slew-limited code register driving a mid-code real VOUT; accepts codes over valid/ready.
// Define RAMP_DAC_SLEW_EN to rate-limit SLEW by STEP; otherwise SLEW loads the target in one cycle.
module ramp_dac #(
    parameter int n          = 3,
    parameter int STEP       = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] D,
    input  logic         d_valid,
    output logic         d_ready,
    input  real          vref,
    output real          VOUT,
    output logic         busy,
    output logic         settled
);
`ifdef RAMP_DAC_SLEW_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif
    // Without rate limiting the step covers the full code range, so every SLEW lands on target.
    localparam int STEP_EFF = SLEW_EN ? STEP : (1 << n) - 1;
    localparam int CW       = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam int LAST     = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
    localparam logic [n-1:0]  STEP_C = n'(STEP_EFF);
    localparam logic [CW-1:0] LAST_C = CW'(LAST);

    typedef enum logic [1:0] {IDLE, SLEW, SETTLE} state_t;

    state_t        state_q, state_d;
    logic [n-1:0]  cur_q, cur_d, tgt_q, tgt_d, mag;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          settled_q, settled_d, up, near;

    always_comb begin
        up   = tgt_q >= cur_q;
        mag  = up ? tgt_q - cur_q : cur_q - tgt_q;
        near = mag <= STEP_C;
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        settled_d = settled_q;
        case (state_q)
            IDLE: begin
                if (d_valid) begin
                    tgt_d     = D;
                    settled_d = 1'b0;
                    state_d   = SLEW;
                end
            end
            SLEW: begin
                // mag > STEP whenever we step, so the step can neither overshoot nor wrap.
                cur_d = near ? tgt_q : (up ? cur_q + STEP_C : cur_q - STEP_C);
                if (near) begin
                    cnt_d = '0;
                    if (SETTLE_CYC == 0) begin
                        state_d   = IDLE;
                        settled_d = 1'b1;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == LAST_C) begin
                    state_d   = IDLE;
                    settled_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            tgt_q     <= '0;
            cnt_q     <= '0;
            settled_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            settled_q <= settled_d;
        end
    end

    assign d_ready = state_q == IDLE;
    assign busy    = state_q != IDLE;
    assign settled = settled_q;
    assign VOUT    = vref * real'(2 * int'(cur_q) + 1) / real'(1 << (n + 1));
endmodule

// File: tb/tb_ramp_dac.sv
// tb_ramp_dac: directed checks of ramp_dac (n=3, STEP=2, SETTLE_CYC=2, vref=1.0).
module tb_ramp_dac;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] D;
    logic       d_valid;
    logic       d_ready, busy, settled;
    real        vref, VOUT;
    int         errors = 0;
    int         checks = 0;

`ifdef RAMP_DAC_SLEW_EN
    localparam int N1 = 6;
    localparam int L1 = 4;
    localparam int K  = 2;
    localparam int KC = 4;
    int up_seq[N1] = '{2, 4, 6, 7, 7, 7};
    int dn_seq[N1] = '{5, 3, 1, 0, 0, 0};
`else
    localparam int N1 = 3;
    localparam int L1 = 3;
    localparam int K  = 0;
    localparam int KC = 0;
    int up_seq[N1] = '{7, 7, 7};
    int dn_seq[N1] = '{0, 0, 0};
`endif

    ramp_dac #(.n(3), .STEP(2), .SETTLE_CYC(2)) dut (
        .clk(clk), .rst(rst), .D(D), .d_valid(d_valid), .d_ready(d_ready),
        .vref(vref), .VOUT(VOUT), .busy(busy), .settled(settled)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_v(input string tag, input int code);
        real exp;
        exp = (2.0 * code + 1.0) / 16.0;
        checks++;
        assert (VOUT == exp) else begin
            errors++;
            $error("FAIL %s VOUT=%f exp=%f", tag, VOUT, exp);
        end
    endtask

    initial begin
        int q;
        int w;
        rst = 1'b1; D = '0; d_valid = 1'b0; vref = 1.0;
        #3;
        chk_v("rst_vout", 0);
        chk("rst_settled", int'(settled), 1);
        chk("rst_ready", int'(d_ready), 1);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        D = 3'd7; d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        chk("up_acc_busy", int'(busy), 1);
        chk("up_acc_ready", int'(d_ready), 0);
        chk("up_acc_settled", int'(settled), 0);
        chk_v("up_acc_vout", 0);
        for (int i = 0; i < N1; i++) begin
            tick();
            chk_v("up_vout", up_seq[i]);
            chk("up_settled", int'(settled), int'(i == N1 - 1));
            chk("up_busy", int'(busy), int'(i != N1 - 1));
        end

        D = 3'd0; d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        chk("dn_acc_busy", int'(busy), 1);
        for (int i = 0; i < N1; i++) begin
            tick();
            chk_v("dn_vout", dn_seq[i]);
            chk("dn_settled", int'(settled), int'(i == N1 - 1));
        end

        D = 3'd3; d_valid = 1'b1;
        tick();
        chk("hold_acc_busy", int'(busy), 1);
        for (int i = 0; i < L1; i++) begin
            tick();
            chk("hold_ready", int'(d_ready), int'(i == L1 - 1));
            chk("hold_settled", int'(settled), int'(i == L1 - 1));
        end
        chk_v("hold_vout", 3);
        tick();
        d_valid = 1'b0;
        chk("reacc_busy", int'(busy), 1);
        chk("reacc_settled", int'(settled), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_v("same_vout", 3);
            chk("same_settled", int'(settled), int'(i == 2));
        end

        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk_v("rst2_vout", 0);
        D = 3'd7; d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        for (int i = 0; i < K; i++) tick();
        chk_v("mid_vout", KC);
        chk("mid_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk_v("abort_vout", 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(d_ready), 1);
        chk("abort_settled", int'(settled), 1);
        tick();
        chk("abort_rst_noacc", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk_v("abort_final_vout", 0);
        chk("abort_final_busy", int'(busy), 0);

        for (int c = 0; c < 8; c++) begin
            D = 3'(c); d_valid = 1'b1;
            tick();
            d_valid = 1'b0;
            w = 0;
            while (!settled && w < 20) begin
                tick();
                w++;
            end
            chk("rt_settled", int'(settled), 1);
            q = $rtoi(VOUT * 8.0 / vref);
            chk("rt_code", q, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
